nn_sequencer: RTL
=================

// Module: nn_sequencer
// PURPOSE
//  Parametrised run controller for the multi-layer NN datapath. Steps forward prop layer 0..L-1, then
//  (train) backprop L-1..0 per sample, requests a weight update every BATCH_SIZE samples and loops
//  over a programmable epoch count. Test mode runs forward only, pulsing display per sample.
//  Sits between the board-level start/train/test inputs and the per-layer forprop/backprop engines.
// PARAMETERS
//  NUM_LAYERS  2   layers driven by layer_idx (>=1)
//  BATCH_SIZE  16  samples per weight update and per test run (>=1)
//  EPOCH_W     8   width of num_epochs / epoch_idx
// PORTS  (LAYER_W=max(1,$clog2(NUM_LAYERS)), SAMPLE_W=max(1,$clog2(BATCH_SIZE)))
//  clk          in   1         clock, all state on rising edge
//  reset        in   1         asynchronous active-low reset (0 = reset)
//  start        in   1         begin a run; sampled only in IDLE
//  train        in   1         select train mode (buffered); wins if test also high
//  test         in   1         select test mode (buffered)
//  abort        in   1         abandon run, return to IDLE
//  num_epochs   in   EPOCH_W   epochs per train run, latched at start; 0 treated as 1
//  fwd_done     in   1         forprop engine finished current layer
//  bwd_done     in   1         backprop engine finished current layer
//  upd_done     in   1         weight-update engine finished
//  fwd_req      out  1         forward request for layer_idx
//  bwd_req      out  1         backward request for layer_idx
//  upd_req      out  1         weight-update request
//  layer_idx    out  LAYER_W   active layer
//  sample_idx   out  SAMPLE_W  sample within batch
//  epoch_idx    out  EPOCH_W   current epoch (0-based)
//  display_val  out  1         one-cycle pulse: sample result ready to display
//  train_mode   out  1         buffered mode (1 = train, 0 = test)
//  busy         out  1         high in every state except IDLE
//  done         out  1         one-cycle pulse: run completed normally
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, all counters 0, mode buffer = test (train_mode=0).
//  Mode buffer: train -> 1, else test -> 0, else hold; updates any cycle; run mode latched at start,
//    mid-run mode changes affect only the next run.
//  States: IDLE, FWD, BWD, UPD, DISP.
//  IDLE: start=1 -> FWD next cycle, layer/sample/epoch = 0, latch mode and max(num_epochs,1).
//  Request handshake: req is a level, high from state entry until done sampled high; req low the
//    cycle after done; layer_idx stable while req high; done ignored when matching req low.
//  FWD: fwd_done & layer<L-1 -> layer+1, stay FWD (req drops 1 cycle, reasserts);
//    fwd_done & last layer -> train: BWD, layer=L-1; test: DISP.
//  BWD: bwd_done & layer>0 -> layer-1, stay BWD; bwd_done & layer 0 -> DISP.
//  DISP: display_val=1 for one cycle; then sample_idx<BATCH_SIZE-1: sample+1, layer=0, FWD;
//    else train: UPD; test: sample_idx wraps to 0, done pulse, IDLE.
//  UPD: upd_req until upd_done; then epoch<epochs-1: epoch+1, sample wraps 0, layer 0, FWD;
//    else done pulse, IDLE.
//  done asserts in the cycle the FSM re-enters IDLE; busy low that same cycle.
//  abort (any non-IDLE state, priority over all done inputs): IDLE next cycle, reqs drop, counters 0,
//    no done pulse, no display pulse. abort in IDLE: no effect. start while busy: ignored.
//  start and abort same cycle in IDLE: abort wins, stay IDLE.
//  Reset asserted mid-run: immediate return to reset values regardless of clk.
//  No counter may wrap past its limit; epoch_idx never exceeds epochs-1.
// TESTING  (NUM_LAYERS=3, BATCH_SIZE=4, engines answer done 2 cycles after req)
//  Test run: test, start -> fwd_req layers 0,1,2 x4 samples, 4 display_val pulses, done, no bwd_req.
//  Train run num_epochs=2 -> per sample FWD 0,1,2 then BWD 2,1,0; upd_req after sample 3 of each
//    epoch (2 total); 8 display pulses; done once with epoch_idx=1.
//  num_epochs=0 in train -> behaves as 1: exactly 1 upd_req, then done.
//  abort during BWD layer 1 of sample 2 -> next cycle IDLE, all reqs 0, idx 0, no done.
//  train toggled to test mid train run -> run finishes in train; train_mode=0; next run is test.
//  reset pulled low while fwd_req=1 -> fwd_req, busy, counters 0 immediately; start needed to resume.

Source files
------------

// File: rtl/nn_sequencer.sv
// Run controller: steps forward/backward layers per sample, weight update per batch, loops epochs.
// Requests are registered levels held until the engine's done; any engine may stall indefinitely.
module nn_sequencer #(
  parameter int NUM_LAYERS = 2,
  parameter int BATCH_SIZE = 16,
  parameter int EPOCH_W    = 8,
  localparam int LAYER_W   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  localparam int SAMPLE_W  = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                train,
  input  logic                test,
  input  logic                abort,
  input  logic [EPOCH_W-1:0]  num_epochs,
  input  logic                fwd_done,
  input  logic                bwd_done,
  input  logic                upd_done,
  output logic                fwd_req,
  output logic                bwd_req,
  output logic                upd_req,
  output logic [LAYER_W-1:0]  layer_idx,
  output logic [SAMPLE_W-1:0] sample_idx,
  output logic [EPOCH_W-1:0]  epoch_idx,
  output logic                display_val,
  output logic                train_mode,
  output logic                busy,
  output logic                done
);

  localparam logic [LAYER_W-1:0]  LAST_LAYER  = LAYER_W'(NUM_LAYERS - 1);
  localparam logic [SAMPLE_W-1:0] LAST_SAMPLE = SAMPLE_W'(BATCH_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FWD,
    S_BWD,
    S_UPD,
    S_DISP
  } state_t;

  state_t             state;
  logic               run_train;
  logic [EPOCH_W-1:0] epoch_last;
  logic               mode_next;

  // Same-cycle train/test inputs take effect for a run started in that cycle.
  assign mode_next = train | (~test & train_mode);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      train_mode <= 1'b0;
    end else begin
      train_mode <= mode_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      run_train   <= 1'b0;
      epoch_last  <= '0;
      fwd_req     <= 1'b0;
      bwd_req     <= 1'b0;
      upd_req     <= 1'b0;
      layer_idx   <= '0;
      sample_idx  <= '0;
      epoch_idx   <= '0;
      display_val <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      display_val <= 1'b0;
      done        <= 1'b0;
      if (abort && state != S_IDLE) begin
        state      <= S_IDLE;
        fwd_req    <= 1'b0;
        bwd_req    <= 1'b0;
        upd_req    <= 1'b0;
        layer_idx  <= '0;
        sample_idx <= '0;
        epoch_idx  <= '0;
        busy       <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              state      <= S_FWD;
              fwd_req    <= 1'b1;
              busy       <= 1'b1;
              layer_idx  <= '0;
              sample_idx <= '0;
              epoch_idx  <= '0;
              run_train  <= mode_next;
              epoch_last <= (num_epochs == '0) ? '0 : num_epochs - EPOCH_W'(1);
            end
          end

          S_FWD: begin
            // A low request here is the one-cycle gap between consecutive layers.
            if (!fwd_req) begin
              fwd_req <= 1'b1;
            end else if (fwd_done) begin
              fwd_req <= 1'b0;
              if (layer_idx != LAST_LAYER) begin
                layer_idx <= layer_idx + LAYER_W'(1);
              end else if (run_train) begin
                state   <= S_BWD;
                bwd_req <= 1'b1;
              end else begin
                state       <= S_DISP;
                display_val <= 1'b1;
              end
            end
          end

          S_BWD: begin
            if (!bwd_req) begin
              bwd_req <= 1'b1;
            end else if (bwd_done) begin
              bwd_req <= 1'b0;
              if (layer_idx != '0) begin
                layer_idx <= layer_idx - LAYER_W'(1);
              end else begin
                state       <= S_DISP;
                display_val <= 1'b1;
              end
            end
          end

          S_DISP: begin
            if (sample_idx != LAST_SAMPLE) begin
              sample_idx <= sample_idx + SAMPLE_W'(1);
              layer_idx  <= '0;
              state      <= S_FWD;
              fwd_req    <= 1'b1;
            end else if (run_train) begin
              state   <= S_UPD;
              upd_req <= 1'b1;
            end else begin
              sample_idx <= '0;
              state      <= S_IDLE;
              busy       <= 1'b0;
              done       <= 1'b1;
            end
          end

          S_UPD: begin
            if (upd_req && upd_done) begin
              upd_req <= 1'b0;
              if (epoch_idx < epoch_last) begin
                epoch_idx  <= epoch_idx + EPOCH_W'(1);
                sample_idx <= '0;
                layer_idx  <= '0;
                state      <= S_FWD;
                fwd_req    <= 1'b1;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end

          default: begin
            state   <= S_IDLE;
            fwd_req <= 1'b0;
            bwd_req <= 1'b0;
            upd_req <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
